// File: rtl/lt24_pixel_streamer.sv
// Reads a run of 32-bit words from the line buffer and streams them as RGB565 pixels.
// Define LT24_STREAM_SWAP_EN to emit the high halfword of each word first.
module lt24_pixel_streamer #(
   parameter int ADDR_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   word_count,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [3:0]        mem_byteenable,
   input  logic [31:0]       mem_readdata,
   output logic [15:0]       pix_data,
   output logic              pix_valid,
   input  logic              pix_ready
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
   localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   ONE_WORD  = (ADDR_W+1)'(1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     remain_q, remain_d;
   logic [ADDR_W:0]     sat_count;
   logic                pend_q, pend_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    fcnt_q, fcnt_d;
   logic [31:0]         word_q, word_d;
   logic                half_q, half_d;
   logic                valid_q, valid_d;
   logic                issue, push, pop, accept, take;
   logic [31:0]         fifo_mem [FIFO_DEPTH];

   // Unpacker refill: the FIFO head has priority; a word arriving from memory
   // goes straight into the unpacker only when the FIFO is empty, preserving order.
   always_comb begin
      word_d  = word_q;
      half_d  = half_q;
      valid_d = valid_q;
      pop     = 1'b0;
      accept  = valid_q & pix_ready;
      take    = !valid_q | (accept & half_q);
      if (accept && !half_q) begin
         half_d = 1'b1;
      end
      if (take) begin
         half_d = 1'b0;
         if (fcnt_q != '0) begin
            word_d  = fifo_mem[rd_ptr_q];
            valid_d = 1'b1;
            pop     = 1'b1;
         end else if (pend_q) begin
            word_d  = mem_readdata;
            valid_d = 1'b1;
         end else begin
            valid_d = 1'b0;
         end
      end
      push     = pend_q & !(take & (fcnt_q == '0));
      fcnt_d   = fcnt_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      remain_d  = remain_q;
      issue     = 1'b0;
      sat_count = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d   = base_addr;
               remain_d = sat_count;
               state_d  = (sat_count == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            // Words in the FIFO plus the read in flight must fit the FIFO.
            issue = (fcnt_q + CNT_W'(pend_q)) < DEPTH_C;
            if (issue) begin
               addr_d   = addr_q + ADDR_W'(1);
               remain_d = remain_q - ONE_WORD;
               if (remain_q == ONE_WORD) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (!valid_d && fcnt_d == '0 && !pend_q) begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      pend_d = issue;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         remain_q <= '0;
         pend_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fcnt_q   <= '0;
         word_q   <= '0;
         half_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         remain_q <= remain_d;
         pend_q   <= pend_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fcnt_q   <= fcnt_d;
         word_q   <= word_d;
         half_q   <= half_d;
         valid_q  <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= mem_readdata;
      end
   end

`ifdef LT24_STREAM_SWAP_EN
   assign pix_data = half_q ? word_q[15:0] : word_q[31:16];
`else
   assign pix_data = half_q ? word_q[31:16] : word_q[15:0];
`endif

   assign pix_valid      = valid_q;
   assign busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done           = (state_q == S_DONE);
   assign mem_address    = addr_q;
   assign mem_chipselect = issue;
   assign mem_write      = 1'b0;
   assign mem_byteenable = 4'hF;
endmodule

// File: tb/tb_lt24_pixel_streamer.sv
// Self-checking bench for lt24_pixel_streamer: buffer model, pixel-order model and
// randomized back-pressure. Honours LT24_STREAM_SWAP_EN for the expected halfword order.
module tb_lt24_pixel_streamer;
   localparam int DEPTH = 4;
   localparam int LIMIT = 3000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  base_addr = '0;
   logic [8:0]  word_count = '0;
   logic        busy, done;
   logic [7:0]  mem_address;
   logic        mem_chipselect, mem_write;
   logic [3:0]  mem_byteenable;
   logic [31:0] mem_readdata = '0;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic        pix_ready = 1'b1;

   logic [31:0] mem [256];
   int checks = 0;
   int errors = 0;

   logic [15:0] exp_pix[$];
   logic [15:0] got_pix[$];
   logic [7:0]  exp_addr[$];
   logic [7:0]  got_addr[$];
   int first_valid, done_idx, last_hs, done_pulses, busy_cycles;
   int stable_err, max_out, reads_after_done, timed_out;
   logic busy_at_done;

   lt24_pixel_streamer #(.ADDR_W(8), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
      .word_count(word_count), .busy(busy), .done(done),
      .mem_address(mem_address), .mem_chipselect(mem_chipselect),
      .mem_write(mem_write), .mem_byteenable(mem_byteenable),
      .mem_readdata(mem_readdata), .pix_data(pix_data),
      .pix_valid(pix_valid), .pix_ready(pix_ready)
   );

   always #5 clk = ~clk;

   // Line buffer with a fixed one-cycle read latency.
   always @(posedge clk) begin
      if (mem_chipselect) mem_readdata <= mem[mem_address];
   end

   function automatic void build_expect(input logic [7:0] b, input int n);
      exp_pix.delete();
      exp_addr.delete();
      for (int i = 0; i < n; i++) begin
         logic [7:0]  a;
         logic [31:0] w;
         a = b + 8'(i);
         w = mem[a];
         exp_addr.push_back(a);
`ifdef LT24_STREAM_SWAP_EN
         exp_pix.push_back(w[31:16]);
         exp_pix.push_back(w[15:0]);
`else
         exp_pix.push_back(w[15:0]);
         exp_pix.push_back(w[31:16]);
`endif
      end
   endfunction

   // rmode: 0 ready always high, 1 ready one cycle in three, 2 random ready.
   // poke: pulse start while busy and in the done cycle (both must be ignored).
   task automatic do_transfer(input logic [7:0] b, input logic [8:0] c, input int rmode, input bit poke);
      int n;
      logic prev_valid, prev_ready, r;
      logic [15:0] prev_data;
      n = (c > 9'd256) ? 256 : int'(c);
      build_expect(b, n);
      got_pix.delete();
      got_addr.delete();
      first_valid = -1; done_idx = -1; last_hs = -1; done_pulses = 0; busy_cycles = 0;
      stable_err = 0; max_out = 0; reads_after_done = 0; timed_out = 0; busy_at_done = 1'b1;
      prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0;
      @(posedge clk); #1;
      start = 1'b1; base_addr = b; word_count = c; pix_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int idx = 1; idx <= LIMIT; idx++) begin
         if (got_addr.size() - got_pix.size() / 2 > max_out) max_out = got_addr.size() - got_pix.size() / 2;
         if (mem_chipselect) begin
            got_addr.push_back(mem_address);
            if (done_idx >= 0) reads_after_done++;
         end
         if (busy) busy_cycles++;
         if (pix_valid && first_valid < 0) first_valid = idx;
         if (prev_valid && !prev_ready && (!pix_valid || pix_data !== prev_data)) stable_err++;
         if (done) begin
            done_pulses++;
            if (done_idx < 0) begin
               done_idx = idx;
               busy_at_done = busy;
            end
         end
         case (rmode)
            0:       r = 1'b1;
            1:       r = (idx % 3 == 0);
            default: r = 1'($urandom_range(0, 1));
         endcase
         pix_ready = r;
         start = poke && ((busy && idx % 4 == 2) || done);
         if (pix_valid && r) begin
            got_pix.push_back(pix_data);
            last_hs = idx;
         end
         prev_valid = pix_valid; prev_ready = r; prev_data = pix_data;
         if (done_idx >= 0 && idx >= done_idx + 3) break;
         @(posedge clk); #1;
      end
      start = 1'b0;
      pix_ready = 1'b1;
      if (done_idx < 0) timed_out = 1;
      $display("transfer base=%0d count=%0d pixels=%0d reads=%0d first_valid=%0d done_at=%0d",
               b, c, got_pix.size(), got_addr.size(), first_valid, done_idx);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b expected 0", mem_chipselect); end
      checks++; if (mem_address !== 8'd0) begin errors++; $display("FAIL reset_addr: got %h expected 00", mem_address); end
      checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b expected 0", mem_write); end
      checks++; if (mem_byteenable !== 4'hF) begin errors++; $display("FAIL reset_be: got %h expected f", mem_byteenable); end
      checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", pix_valid); end
      checks++; if (pix_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h expected 0000", pix_data); end
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_basic();
      do_transfer(8'd0, 9'd4, 0, 1'b0);
      checks++; if (timed_out != 0) begin errors++; $display("FAIL basic_timeout: no done within %0d cycles", LIMIT); end
      checks++; if (got_pix.size() != 8) begin errors++; $display("FAIL basic_npix: got %0d expected 8", got_pix.size()); end
      for (int i = 0; i < exp_pix.size(); i++) begin
         checks++;
         if (i >= got_pix.size() || got_pix[i] !== exp_pix[i]) begin
            errors++; $display("FAIL basic_pix[%0d]: got %h expected %h", i, (i < got_pix.size()) ? got_pix[i] : 16'hxxxx, exp_pix[i]);
         end
      end
      checks++; if (first_valid != 3) begin errors++; $display("FAIL basic_first_valid: got T+%0d expected T+3", first_valid); end
      checks++; if (last_hs - first_valid != 7) begin errors++; $display("FAIL basic_throughput: got span %0d expected 7", last_hs - first_valid); end
      checks++; if (done_idx != last_hs + 1) begin errors++; $display("FAIL basic_done_time: got %0d expected %0d", done_idx, last_hs + 1); end
      checks++; if (done_pulses != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d expected 1", done_pulses); end
      checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b expected 0", busy_at_done); end
      checks++; if (busy_cycles != done_idx - 1) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected %0d", busy_cycles, done_idx - 1); end
      checks++; if (got_addr.size() != 4) begin errors++; $display("FAIL basic_reads: got %0d expected 4", got_addr.size()); end
   endtask

   task automatic test_backpressure();
      do_transfer(8'd0, 9'd4, 1, 1'b0);
      checks++; if (got_pix.size() != 8) begin errors++; $display("FAIL bp_npix: got %0d expected 8", got_pix.size()); end
      for (int i = 0; i < exp_pix.size(); i++) begin
         checks++;
         if (i >= got_pix.size() || got_pix[i] !== exp_pix[i]) begin
            errors++; $display("FAIL bp_pix[%0d]: got %h expected %h", i, (i < got_pix.size()) ? got_pix[i] : 16'hxxxx, exp_pix[i]);
         end
      end
      checks++; if (stable_err != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", stable_err); end
      checks++; if (max_out > DEPTH + 1) begin errors++; $display("FAIL bp_outstanding: got %0d words expected at most %0d", max_out, DEPTH + 1); end
      checks++; if (got_addr.size() != 4) begin errors++; $display("FAIL bp_reads: got %0d expected 4", got_addr.size()); end
      checks++; if (done_idx != last_hs + 1) begin errors++; $display("FAIL bp_done_time: got %0d expected %0d", done_idx, last_hs + 1); end
   endtask

   task automatic test_wrap();
      do_transfer(8'd254, 9'd4, 0, 1'b0);
      checks++; if (got_addr.size() != 4) begin errors++; $display("FAIL wrap_reads: got %0d expected 4", got_addr.size()); end
      for (int i = 0; i < exp_addr.size(); i++) begin
         checks++;
         if (i >= got_addr.size() || got_addr[i] !== exp_addr[i]) begin
            errors++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, (i < got_addr.size()) ? got_addr[i] : 8'hxx, exp_addr[i]);
         end
      end
      for (int i = 0; i < exp_pix.size(); i++) begin
         checks++;
         if (i >= got_pix.size() || got_pix[i] !== exp_pix[i]) begin
            errors++; $display("FAIL wrap_pix[%0d]: got %h expected %h", i, (i < got_pix.size()) ? got_pix[i] : 16'hxxxx, exp_pix[i]);
         end
      end
   endtask

   task automatic test_zero();
      do_transfer(8'd77, 9'd0, 0, 1'b0);
      checks++; if (done_idx != 1) begin errors++; $display("FAIL zero_done_time: got T+%0d expected T+1", done_idx); end
      checks++; if (got_addr.size() != 0) begin errors++; $display("FAIL zero_reads: got %0d expected 0", got_addr.size()); end
      checks++; if (busy_cycles != 0) begin errors++; $display("FAIL zero_busy: got %0d busy cycles expected 0", busy_cycles); end
      checks++; if (got_pix.size() != 0) begin errors++; $display("FAIL zero_npix: got %0d expected 0", got_pix.size()); end
      checks++; if (done_pulses != 1) begin errors++; $display("FAIL zero_done_pulses: got %0d expected 1", done_pulses); end
   endtask

   task automatic test_saturate();
      do_transfer(8'($urandom), 9'd300, 0, 1'b0);
      checks++; if (got_addr.size() != 256) begin errors++; $display("FAIL sat_reads: got %0d expected 256", got_addr.size()); end
      checks++; if (got_pix.size() != 512) begin errors++; $display("FAIL sat_npix: got %0d expected 512", got_pix.size()); end
      for (int i = 0; i < exp_pix.size(); i++) begin
         checks++;
         if (i >= got_pix.size() || got_pix[i] !== exp_pix[i]) begin
            errors++; $display("FAIL sat_pix[%0d]: got %h expected %h", i, (i < got_pix.size()) ? got_pix[i] : 16'hxxxx, exp_pix[i]);
         end
      end
      checks++; if (last_hs - first_valid != 511) begin errors++; $display("FAIL sat_throughput: got span %0d expected 511", last_hs - first_valid); end
   endtask

   task automatic test_start_ignored();
      do_transfer(8'd10, 9'd6, 2, 1'b1);
      checks++; if (got_pix.size() != 12) begin errors++; $display("FAIL ign_npix: got %0d expected 12", got_pix.size()); end
      for (int i = 0; i < exp_pix.size(); i++) begin
         checks++;
         if (i >= got_pix.size() || got_pix[i] !== exp_pix[i]) begin
            errors++; $display("FAIL ign_pix[%0d]: got %h expected %h", i, (i < got_pix.size()) ? got_pix[i] : 16'hxxxx, exp_pix[i]);
         end
      end
      checks++; if (got_addr.size() != 6) begin errors++; $display("FAIL ign_reads: got %0d expected 6", got_addr.size()); end
      checks++; if (reads_after_done != 0) begin errors++; $display("FAIL ign_reads_after_done: got %0d expected 0", reads_after_done); end
      checks++; if (done_pulses != 1) begin errors++; $display("FAIL ign_done_pulses: got %0d expected 1", done_pulses); end
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      start = 1'b1; base_addr = 8'd40; word_count = 9'd8; pix_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", done); end
      checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL rstmid_cs: got %b expected 0", mem_chipselect); end
      checks++; if (mem_address !== 8'd0) begin errors++; $display("FAIL rstmid_addr: got %h expected 00", mem_address); end
      checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", pix_valid); end
      checks++; if (pix_data !== 16'h0) begin errors++; $display("FAIL rstmid_data: got %h expected 0000", pix_data); end
      @(posedge clk); #1;
      reset_n = 1'b1;
      pix_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (pix_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_stale: got valid=%b done=%b expected 0 0", pix_valid, done); end
      do_transfer(8'd60, 9'd3, 0, 1'b0);
      checks++; if (got_pix.size() != 6) begin errors++; $display("FAIL rstmid_npix: got %0d expected 6", got_pix.size()); end
      for (int i = 0; i < exp_pix.size(); i++) begin
         checks++;
         if (i >= got_pix.size() || got_pix[i] !== exp_pix[i]) begin
            errors++; $display("FAIL rstmid_pix[%0d]: got %h expected %h", i, (i < got_pix.size()) ? got_pix[i] : 16'hxxxx, exp_pix[i]);
         end
      end
      checks++; if (first_valid != 3) begin errors++; $display("FAIL rstmid_first_valid: got T+%0d expected T+3", first_valid); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      for (int k = 0; k < 6; k++) begin
         logic [7:0] b;
         logic [8:0] c;
         b = 8'($urandom);
         c = 9'($urandom_range(1, 40));
         do_transfer(b, c, 2, 1'b0);
         checks++; if (timed_out != 0) begin errors++; $display("FAIL rand%0d_timeout: no done within %0d cycles", k, LIMIT); end
         checks++; if (got_addr.size() != int'(c)) begin errors++; $display("FAIL rand%0d_reads: got %0d expected %0d", k, got_addr.size(), c); end
         checks++; if (stable_err != 0) begin errors++; $display("FAIL rand%0d_stable: got %0d expected 0", k, stable_err); end
         checks++; if (max_out > DEPTH + 1) begin errors++; $display("FAIL rand%0d_outstanding: got %0d expected at most %0d", k, max_out, DEPTH + 1); end
         checks++; if (got_pix.size() != exp_pix.size()) begin errors++; $display("FAIL rand%0d_npix: got %0d expected %0d", k, got_pix.size(), exp_pix.size()); end
         for (int i = 0; i < exp_pix.size(); i++) begin
            checks++;
            if (i >= got_pix.size() || got_pix[i] !== exp_pix[i]) begin
               errors++; $display("FAIL rand%0d_pix[%0d]: got %h expected %h", k, i, (i < got_pix.size()) ? got_pix[i] : 16'hxxxx, exp_pix[i]);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = {8'hA0 ^ 8'(i * 7), 8'(i), 8'h50, 8'(i)};
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_zero();
      test_saturate();
      test_start_ignored();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
